// File: rtl/fl_ckpt_ctrl.sv
// rtl/fl_ckpt_ctrl.sv - branch checkpoint controller for the 3-wide rename freelist head pointer
module fl_ckpt_ctrl #(
  parameter int CKPT_NUM  = 4,
  parameter int TAG_W     = 2,
  parameter int HP_W      = 6,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        br_slot,
  input  logic [2:0]        dispatch_en,
  input  logic [HP_W-1:0]   fl_head,
  input  logic              res_valid,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic              res_mispred,
  output logic [2:0]        dispatch_allow,
  output logic [TAG_W-1:0]  ckpt_tag,
  output logic              restore_en,
  output logic [HP_W-1:0]   restore_head,
  output logic [TAG_W:0]    ckpt_count,
  output logic              res_err
);

  typedef enum logic [1:0] {S_RUN, S_RECOVER, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_drain_cnt;
  logic [HP_W-1:0]   r_entry [CKPT_NUM];
  logic [TAG_W-1:0]  r_alloc_ptr, r_old_ptr;
  logic [TAG_W:0]    r_count;
  logic              r_restore_en, r_res_err;
  logic [HP_W-1:0]   r_restore_head;

  logic [2:0]        w_first_mask, w_first_hot;
  logic              w_has_br, w_second, w_full, w_run;
  logic              w_tag_ok, w_res_ok, w_mispred, w_free, w_alloc;
  logic [HP_W-1:0]   w_pc, w_snap;

  // w_first_mask covers the oldest branch slot and every slot older than it
  always_comb begin
    w_first_mask = 3'b000;
    w_first_hot  = 3'b000;
    if (br_slot[2]) begin
      w_first_mask = 3'b100;
      w_first_hot  = 3'b100;
    end else if (br_slot[1]) begin
      w_first_mask = 3'b110;
      w_first_hot  = 3'b010;
    end else if (br_slot[0]) begin
      w_first_mask = 3'b111;
      w_first_hot  = 3'b001;
    end
  end

  assign w_has_br  = |br_slot;
  assign w_second  = |(br_slot & ~w_first_mask);
  assign w_full    = (r_count == (TAG_W+1)'(CKPT_NUM));
  assign w_run     = (r_state == S_RUN);
  assign w_tag_ok  = (r_count != '0) && (res_tag == r_old_ptr);
  assign w_res_ok  = w_run & res_valid & w_tag_ok;
  assign w_mispred = w_res_ok & res_mispred;
  assign w_free    = w_res_ok & ~res_mispred;
  assign w_alloc   = w_run & w_has_br & (|(dispatch_en & w_first_hot)) & ~w_full;

  // Snapshot counts the branch's own allocation plus every older dispatched slot
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < 3; i++) begin
      w_pc = w_pc + HP_W'(dispatch_en[i] & w_first_mask[i]);
    end
  end
  assign w_snap = fl_head + w_pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RECOVER) r_drain_cnt <= 4'(DRAIN_CYC - 1);
      else if (r_state == S_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:     if (w_mispred) w_next = S_RECOVER;
      S_RECOVER: w_next = S_DRAIN;
      S_DRAIN:   if (r_drain_cnt == '0) w_next = S_RUN;
      default:   w_next = S_RUN;
    endcase
  end

  always_comb begin
    dispatch_allow = 3'b000;
    if (w_run) begin
      if (!w_has_br)    dispatch_allow = 3'b111;
      else if (w_full)  dispatch_allow = w_first_mask & ~w_first_hot;
      else if (w_second) dispatch_allow = w_first_mask;
      else              dispatch_allow = 3'b111;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_alloc_ptr    <= '0;
      r_old_ptr      <= '0;
      r_count        <= '0;
      r_restore_en   <= 1'b0;
      r_restore_head <= '0;
      r_res_err      <= 1'b0;
    end else begin
      r_restore_en <= w_mispred;
      if (w_run && res_valid && !w_tag_ok) r_res_err <= 1'b1;
      if (w_mispred) begin
        r_restore_head <= r_entry[res_tag];
        r_count        <= '0;
        r_alloc_ptr    <= '0;
        r_old_ptr      <= '0;
      end else begin
        if (w_alloc) r_alloc_ptr <= r_alloc_ptr + 1'b1;
        if (w_free)  r_old_ptr   <= r_old_ptr + 1'b1;
        if (w_alloc && !w_free)      r_count <= r_count + 1'b1;
        else if (!w_alloc && w_free) r_count <= r_count - 1'b1;
      end
    end
  end

  // Head snapshots need no reset: they are only read behind a valid tag
  always_ff @(posedge clock) begin
    if (w_alloc && !w_mispred) r_entry[r_alloc_ptr] <= w_snap;
  end

  assign ckpt_tag     = r_alloc_ptr;
  assign restore_en   = r_restore_en;
  assign restore_head = r_restore_head;
  assign ckpt_count   = r_count;
  assign res_err      = r_res_err;

endmodule
